// File: rtl/verificador_clave_if.sv
// Link between the keypad accumulator and the password checker:
// packed code word, sticky event flags and the acknowledge level back.
interface verificador_clave_if;
    logic [31:0] data_i;
    logic [2:0]  cmd_i;
    logic        cmd_o;

    // Accumulator side: produces code and flags, receives the acknowledge.
    modport master (output data_i, output cmd_i, input cmd_o);
    // Checker side: consumes code and flags, returns the acknowledge.
    modport slave  (input data_i, input cmd_i, output cmd_o);
endinterface

// File: rtl/verificador_clave.sv
// Password checker for the security lock: compares a 3-digit ASCII code
// against the stored password, drives the unlock output, counts failed
// attempts with alarm lockout, and allows a password change while open.
module verificador_clave #(
    parameter logic [23:0] CLAVE_DEFECTO = 24'h313233,
    parameter int          MAX_INTENTOS  = 3,
    parameter int          T_ABIERTO     = 50000000,
    parameter int          T_BLOQUEO     = 250000000
) (
    input  logic                      clk,
    input  logic                      reset,
    verificador_clave_if.slave        bus,
    output logic                      abrir,
    output logic                      bloqueado,
    output logic                      alarma,
    output logic [2:0]                fallos,
    output logic                      clave_cambiada
);

    localparam logic [1:0] ESPERA    = 2'd0;
    localparam logic [1:0] COMPARAR  = 2'd1;
    localparam logic [1:0] ABIERTO   = 2'd2;
    localparam logic [1:0] BLOQUEADO = 2'd3;

    localparam logic [2:0]  MAX_FALLOS   = 3'(MAX_INTENTOS);
    localparam logic [27:0] T_ABIERTO_M1 = 28'(T_ABIERTO - 1);
    localparam logic [27:0] T_BLOQUEO_M1 = 28'(T_BLOQUEO - 1);

    logic [2:0]  s1_q, s2_q, s3_q;
    logic [2:0]  s1_d, s2_d, s3_d;
    logic [2:0]  evento;
    logic        ack_q, ack_d;
    logic [1:0]  state_q, state_d;
    logic [23:0] clave_q, clave_d;
    logic [23:0] codigo_q, codigo_d;
    logic [2:0]  fallos_q, fallos_d;
    logic [27:0] timer_q, timer_d;
    logic        abrir_q, abrir_d;
    logic        bloq_q, bloq_d;
    logic        cambiada_q, cambiada_d;
    logic        ev_terminar, ev_limpiar;

    // The upper byte holds an older fourth digit that never matters here.
    logic        unused_alto;
    assign unused_alto = ^bus.data_i[31:24];

    // Synchronizer, rising-edge detection and the acknowledge level.
    always_comb begin
        s1_d   = bus.cmd_i;
        s2_d   = s1_q;
        s3_d   = s2_q;
        evento = s2_q & ~s3_q;
        ack_d  = ack_q;
        if (|evento) begin
            ack_d = 1'b1;
        end else if (s2_q == 3'b000) begin
            ack_d = 1'b0;
        end
    end

    assign ev_terminar = evento[2];
    assign ev_limpiar  = evento[1];

    // Lock state machine: capture, compare, open window and lockout timing.
    always_comb begin
        state_d    = state_q;
        clave_d    = clave_q;
        codigo_d   = codigo_q;
        fallos_d   = fallos_q;
        timer_d    = timer_q;
        cambiada_d = 1'b0;
        case (state_q)
            ESPERA: begin
                if (ev_terminar) begin
                    codigo_d = bus.data_i[23:0];
                    state_d  = COMPARAR;
                end
            end
            COMPARAR: begin
                if (codigo_q == clave_q) begin
                    fallos_d = 3'd0;
                    timer_d  = T_ABIERTO_M1;
                    state_d  = ABIERTO;
                end else if (fallos_q + 3'd1 == MAX_FALLOS) begin
                    fallos_d = MAX_FALLOS;
                    timer_d  = T_BLOQUEO_M1;
                    state_d  = BLOQUEADO;
                end else begin
                    fallos_d = fallos_q + 3'd1;
                    state_d  = ESPERA;
                end
            end
            ABIERTO: begin
                if (ev_limpiar) begin
                    state_d = ESPERA;
                end else if (ev_terminar) begin
                    clave_d    = bus.data_i[23:0];
                    cambiada_d = 1'b1;
                    state_d    = ESPERA;
                end else if (timer_q == 28'd0) begin
                    state_d = ESPERA;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end
            BLOQUEADO: begin
                if (timer_q == 28'd0) begin
                    fallos_d = 3'd0;
                    state_d  = ESPERA;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end
            default: state_d = ESPERA;
        endcase
        abrir_d = (state_d == ABIERTO);
        bloq_d  = (state_d == BLOQUEADO);
    end

    // All state and outputs register here so the lock drives never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= 3'b000;
            s2_q       <= 3'b000;
            s3_q       <= 3'b000;
            ack_q      <= 1'b0;
            state_q    <= ESPERA;
            clave_q    <= CLAVE_DEFECTO;
            codigo_q   <= 24'd0;
            fallos_q   <= 3'd0;
            timer_q    <= 28'd0;
            abrir_q    <= 1'b0;
            bloq_q     <= 1'b0;
            cambiada_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            ack_q      <= ack_d;
            state_q    <= state_d;
            clave_q    <= clave_d;
            codigo_q   <= codigo_d;
            fallos_q   <= fallos_d;
            timer_q    <= timer_d;
            abrir_q    <= abrir_d;
            bloq_q     <= bloq_d;
            cambiada_q <= cambiada_d;
        end
    end

    assign bus.cmd_o      = ack_q;
    assign abrir          = abrir_q;
    assign bloqueado      = bloq_q;
    assign alarma         = bloq_q;
    assign fallos         = fallos_q;
    assign clave_cambiada = cambiada_q;

endmodule

// File: doc/verificador_clave.md
Name: verificador_clave

Overview:
- Downstream stage of the keypad accumulator in the security lock path; consumes its packed 32-bit code word and its 3-bit event flags {terminar, limpiar, digito}.
- Compares the entered 3-digit ASCII code against a stored password.
- Drives the unlock output and counts failed attempts, with alarm lockout after a set number of failures.
- Allows the password to be changed while unlocked.
- Returns an acknowledge level that the accumulator uses to clear its sticky flags.

Parameters:
- CLAVE_DEFECTO, 24'h313233, reset/default password; ASCII "123", most-significant byte is the first digit.
- MAX_INTENTOS, 3, consecutive failures that trigger lockout (1..7).
- T_ABIERTO, 50000000, cycles that abrir stays high (>=1, fits 28 bits).
- T_BLOQUEO, 250000000, cycles of lockout/alarm (>=1, fits 28 bits).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately.
- data_i  in  32  packed code from the accumulator; only [23:0] (last 3 digits) is significant.
- cmd_i  in  3  accumulator flags [2]=terminar, [1]=limpiar, [0]=digito; asynchronous to clk, level, sticky.
- cmd_o  out  1  acknowledge level to the accumulator.
- abrir  out  1  unlock drive.
- bloqueado  out  1  lockout active.
- alarma  out  1  alarm drive; equals bloqueado.
- fallos  out  3  current consecutive failure count.
- clave_cambiada  out  1  one-cycle pulse when the password is replaced.

Behaviour:
- Reset (reset=0, async):
  - state=ESPERA, clave=CLAVE_DEFECTO, fallos=0, timer=0.
  - Sync registers cleared; all outputs 0.
- Input synchronisation and edge detection:
  - cmd_i passes through a 2-flop synchronizer (s1, s2) plus a history register s3.
  - Event per bit = s2 & ~s3.
  - A flag must return to 0 (as seen in s2) before it can generate another event.
  - data_i is sampled unsynchronised only when a terminar event is detected; it has been stable for at least 2 cycles by then.
- Acknowledge:
  - cmd_o is registered; it rises the cycle after any event is detected, in any state.
  - It stays high until s2==3'b000, then falls on the next edge.
- States: ESPERA, COMPARAR, ABIERTO, BLOQUEADO.
- ESPERA:
  - terminar event: capture data_i[23:0], go to COMPARAR.
  - limpiar and digito events: ack only.
  - terminar and limpiar events in the same cycle: terminar is processed.
- COMPARAR (exactly 1 cycle):
  - Match: fallos=0, timer=T_ABIERTO-1, go to ABIERTO.
  - Mismatch with fallos+1 == MAX_INTENTOS: fallos=MAX_INTENTOS, timer=T_BLOQUEO-1, go to BLOQUEADO.
  - Other mismatch: fallos=fallos+1, go to ESPERA.
  - Events arriving during COMPARAR are acked but not processed.
- ABIERTO:
  - abrir=1 for exactly T_ABIERTO cycles unless left early; timer decrements each cycle.
  - timer==0: go to ESPERA.
  - limpiar event: go to ESPERA next edge (early relock); limpiar has priority over a same-cycle terminar.
  - terminar event alone: clave=data_i[23:0], clave_cambiada pulses for 1 cycle, go to ESPERA.
- BLOQUEADO:
  - bloqueado=alarma=1 for exactly T_BLOQUEO cycles; every event is acked and ignored.
  - timer==0: fallos=0, go to ESPERA.
- Output decode:
  - abrir = (state==ABIERTO); bloqueado = alarma = (state==BLOQUEADO).
  - All outputs are driven from registers, glitch-free.
- Latency: cmd_i[2] rising with a correct code makes abrir rise on the 4th clk edge after it (s1, s2/detect, COMPARAR, ABIERTO).
- data_i[31:24] never affects the result (accumulator keeps a 4th older digit there).
- timer is 28 bits; a 3-bit fallos cannot overflow because MAX_INTENTOS<=7.

Test Plan (T_ABIERTO=8, T_BLOQUEO=16, MAX_INTENTOS=3, CLAVE_DEFECTO=24'h313233):
- Correct code: data_i=32'h00313233, cmd_i 000->100.
  - abrir rises on the 4th edge and stays high 8 cycles; fallos=0.
  - cmd_o rises, then falls 3 edges after cmd_i returns to 000.
- Extra digit: data_i=32'h34313233 with terminar event -> opens identically (upper byte ignored).
- Lockout: three terminar events with data_i=32'h00313234, cmd_i toggled 100->000 between them.
  - fallos goes 1, 2, then bloqueado=alarma=1 for 16 cycles.
  - A correct code during lockout is acked but does not open.
  - fallos=0 after exit.
- Password change:
  - Open with "123", then data_i=32'h00343536 with a new terminar event -> clave_cambiada pulses 1 cycle, abrir drops.
  - Then "123" -> fallos=1; "456" -> opens, fallos=0.
- Clear while open: limpiar event during ABIERTO -> abrir falls next edge.
  - limpiar and terminar rising together in ABIERTO -> relock, clave_cambiada stays 0, password unchanged.
- Mid-operation reset: change password, open, assert reset=0 mid-ABIERTO.
  - All outputs 0 immediately, without waiting for clk.
  - After release, "123" opens and the changed password fails.
